// File: rtl/eeprom_spi_slave_pkg.sv
// Shared types and constants for the calibration EEPROM SPI responder.
// Optional feature macro used across the slice: EEPROM_WR_PROTECT_EN (adds a wp input).
package eeprom_pkg;

  localparam int unsigned FRAME_W       = 16;
  localparam int unsigned ADDR_W        = 6;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned CNT_W         = 5;
  localparam int unsigned SYNC_STG_DFLT = 2;

  typedef enum logic [1:0] {
    OP_RD = 2'b00,
    OP_WR = 2'b01
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DECODE
  } state_t;

  // Array address layout: {channel, gain code, sel}; sel=1 gain byte, sel=0 offset byte.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [1:0] ch, input logic [2:0] ggg,
                                                  input logic sel);
    return {ch, ggg, sel};
  endfunction

endpackage

// File: rtl/eeprom_spi_slave_if.sv
// SPI link plus status pulses between a master (dump / cal-write path) and the EEPROM model.
// Signals: SS_n, SCLK, MOSI (master -> slave), MISO, wrt_done, rd_done, frame_err, busy
// (slave -> master). With EEPROM_WR_PROTECT_EN defined, wp (master -> slave) is added.
interface eeprom_spi_slave_if;

  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic wrt_done;
  logic rd_done;
  logic frame_err;
  logic busy;
`ifdef EEPROM_WR_PROTECT_EN
  logic wp;
`endif

  modport master (
`ifdef EEPROM_WR_PROTECT_EN
    output wp,
`endif
    output SS_n, SCLK, MOSI,
    input  MISO, wrt_done, rd_done, frame_err, busy
  );

  modport slave (
`ifdef EEPROM_WR_PROTECT_EN
    input  wp,
`endif
    input  SS_n, SCLK, MOSI,
    output MISO, wrt_done, rd_done, frame_err, busy
  );

endinterface

// File: rtl/eeprom_spi_slave_spi_in_sync.sv
// Synchronizers and edge detection for the asynchronous SPI inputs.
// Ports: clk, rst (sync, active high); ss_n_i, sclk_i, mosi_i raw pins (wp_i when
// EEPROM_WR_PROTECT_EN is defined); outputs ss_n_s, mosi_s synced levels, sclk_rise,
// sclk_fall, ss_rise, ss_fall single-cycle edge strobes (wp_s synced level when enabled).
module spi_in_sync #(
  parameter int unsigned SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_n_i,
  input  logic sclk_i,
  input  logic mosi_i,
`ifdef EEPROM_WR_PROTECT_EN
  input  logic wp_i,
  output logic wp_s,
`endif
  output logic ss_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_rise,
  output logic ss_fall
);

  logic [SYNC_STG-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STG-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;
  logic                ss_prev_q, ss_prev_d;
  logic                sclk_prev_q, sclk_prev_d;
`ifdef EEPROM_WR_PROTECT_EN
  logic [SYNC_STG-1:0] wp_sync_q, wp_sync_d;
`endif

  always_comb begin
    ss_sync_d      = ss_sync_q;
    sclk_sync_d    = sclk_sync_q;
    mosi_sync_d    = mosi_sync_q;
    ss_sync_d[0]   = ss_n_i;
    sclk_sync_d[0] = sclk_i;
    mosi_sync_d[0] = mosi_i;
    for (int i = 1; i < int'(SYNC_STG); i++) begin
      ss_sync_d[i]   = ss_sync_q[i-1];
      sclk_sync_d[i] = sclk_sync_q[i-1];
      mosi_sync_d[i] = mosi_sync_q[i-1];
    end
`ifdef EEPROM_WR_PROTECT_EN
    wp_sync_d    = wp_sync_q;
    wp_sync_d[0] = wp_i;
    for (int i = 1; i < int'(SYNC_STG); i++) begin
      wp_sync_d[i] = wp_sync_q[i-1];
    end
`endif
    ss_prev_d   = ss_n_s;
    sclk_prev_d = sclk_sync_q[SYNC_STG-1];
  end

  // SS_n clears to its inactive (high) level so leaving reset never fakes a select edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
`ifdef EEPROM_WR_PROTECT_EN
      wp_sync_q   <= '0;
`endif
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_prev_q   <= ss_prev_d;
      sclk_prev_q <= sclk_prev_d;
`ifdef EEPROM_WR_PROTECT_EN
      wp_sync_q   <= wp_sync_d;
`endif
    end
  end

  assign ss_n_s    = ss_sync_q[SYNC_STG-1];
  assign mosi_s    = mosi_sync_q[SYNC_STG-1];
  assign sclk_rise = sclk_sync_q[SYNC_STG-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[SYNC_STG-1] & sclk_prev_q;
  assign ss_rise   = ss_n_s & ~ss_prev_q;
  assign ss_fall   = ~ss_n_s & ss_prev_q;
`ifdef EEPROM_WR_PROTECT_EN
  assign wp_s      = wp_sync_q[SYNC_STG-1];
`endif

endmodule

// File: rtl/eeprom_spi_slave.sv
// SPI responder model of the calibration EEPROM (64 x 8 gain/offset bytes).
// Decodes 16-bit frames {opcode[1:0], addr[5:0], data[7:0]}; a read's byte is returned in
// bits [7:0] of the following frame. Writes echo their data into the read register.
// Ports: clk, rst (sync, active high); spi (slave modport): SS_n, SCLK, MOSI in, MISO out,
// wrt_done / rd_done / frame_err single-cycle pulses, busy level.
// Optional: EEPROM_WR_PROTECT_EN adds spi.wp; a write with wp=1 is rejected as a frame error.
module eeprom_spi_slave
  import eeprom_pkg::*;
#(
  parameter int unsigned SYNC_STG = SYNC_STG_DFLT
) (
  input logic               clk,
  input logic               rst,
  eeprom_spi_slave_if.slave spi
);

  logic ss_n_s, mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic wp_block;

  spi_in_sync #(
    .SYNC_STG (SYNC_STG)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .ss_n_i    (spi.SS_n),
    .sclk_i    (spi.SCLK),
    .mosi_i    (spi.MOSI),
`ifdef EEPROM_WR_PROTECT_EN
    .wp_i      (spi.wp),
    .wp_s      (wp_block),
`endif
    .ss_n_s    (ss_n_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_rise   (ss_rise),
    .ss_fall   (ss_fall)
  );

`ifndef EEPROM_WR_PROTECT_EN
  assign wp_block = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [FRAME_W-1:0]  rx_q, rx_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic                wrt_done_q, wrt_done_d;
  logic                rd_done_q, rd_done_d;
  logic                frame_err_q, frame_err_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic                mem_we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                frame_ok;

  assign addr     = pack_addr(rx_q[13:12], rx_q[11:9], rx_q[8]);
  assign wdata    = rx_q[DATA_W-1:0];
  assign frame_ok = (count_q == CNT_W'(FRAME_W));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rd_data_d   = rd_data_q;
    busy_d      = busy_q;
    wrt_done_d  = 1'b0;
    rd_done_d   = 1'b0;
    frame_err_d = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Level term picks up a select that fell while we were still in DECODE.
        if (ss_fall || !ss_n_s) begin
          tx_d    = {{(FRAME_W-DATA_W){1'b0}}, rd_data_q};
          count_d = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_d = {rx_q[FRAME_W-2:0], mosi_s};
          if (count_q != '1) count_d = count_q + 1'b1;
        end
        if (sclk_fall) tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        if (ss_rise) state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (frame_ok && rx_q[15:14] == OP_RD) begin
          rd_data_d = mem_q[addr];
          rd_done_d = 1'b1;
        end else if (frame_ok && rx_q[15:14] == OP_WR && !wp_block) begin
          mem_we     = 1'b1;
          rd_data_d  = wdata;
          wrt_done_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      wrt_done_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      wrt_done_q  <= wrt_done_d;
      rd_done_q   <= rd_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr] <= wdata;
  end

  assign spi.MISO      = tx_q[FRAME_W-1] & ~ss_n_s;
  assign spi.wrt_done  = wrt_done_q;
  assign spi.rd_done   = rd_done_q;
  assign spi.frame_err = frame_err_q;
  assign spi.busy      = busy_q;

endmodule

// File: tb/tb_eeprom_spi_slave.sv
module tb_eeprom_spi_slave;
  import eeprom_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eeprom_spi_slave_if spi ();

  eeprom_spi_slave dut (
    .clk (clk),
    .rst (rst),
    .spi (spi.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_wr   = 0;
  int n_rd   = 0;
  int n_err  = 0;

  always @(negedge clk) begin
    if (spi.wrt_done === 1'b1) n_wr <= n_wr + 1;
    if (spi.rd_done === 1'b1) n_rd <= n_rd + 1;
    if (spi.frame_err === 1'b1) n_err <= n_err + 1;
  end

  // Reference model: what the EEPROM should hold and what the next frame should return.
  logic [7:0] m_mem [64];
  bit         m_ok  [64];
  logic [7:0] m_rdq;
  bit         m_rdq_ok;
  bit         wp_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame (MSB first, mode 0, 8 clk per SCLK period). rst_after>0 pulses rst
  // after that many SCLK rises and abandons the frame.
  task automatic xfer(input logic [15:0] cmd, input int nbits, input int rst_after,
                      output logic [15:0] miso_w, output logic busy_mid);
    miso_w   = '0;
    busy_mid = 1'b0;
    spi.SS_n = 1'b0;
    wclk(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) spi.MOSI = cmd[15-i];
      else spi.MOSI = 1'b0;
      wclk(4);
      if (i < 16) miso_w[15-i] = spi.MISO;
      if (i == 0) busy_mid = spi.busy;
      spi.SCLK = 1'b1;
      wclk(4);
      if (rst_after > 0 && i + 1 == rst_after) begin
        rst = 1'b1;
        wclk(2);
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b0;
        wclk(2);
        chk("rst_mid_miso", {31'd0, spi.MISO}, 32'd0);
        chk("rst_mid_busy", {31'd0, spi.busy}, 32'd0);
        rst = 1'b0;
        wclk(8);
        return;
      end
      spi.SCLK = 1'b0;
    end
    wclk(4);
    spi.SS_n = 1'b1;
    wclk(10);
  endtask

  task automatic frame(input logic [15:0] cmd, input int nbits, input string tag);
    logic [15:0] got, exp_miso;
    logic        bm;
    bit          miso_ok;
    int          w0, r0, e0, ew, er, ee;
    logic [5:0]  a;
    exp_miso = {8'h00, m_rdq};
    miso_ok  = m_rdq_ok;
    w0 = n_wr; r0 = n_rd; e0 = n_err;
    xfer(cmd, nbits, 0, got, bm);
    a  = cmd[13:8];
    ew = 0; er = 0; ee = 0;
    if (nbits == 16 && cmd[15:14] == 2'b00) begin
      er = 1;
      m_rdq = m_mem[a];
      m_rdq_ok = m_ok[a];
    end else if (nbits == 16 && cmd[15:14] == 2'b01 && !wp_m) begin
      ew = 1;
      m_mem[a] = cmd[7:0];
      m_ok[a] = 1'b1;
      m_rdq = cmd[7:0];
      m_rdq_ok = 1'b1;
    end else begin
      ee = 1;
    end
    chk({tag, "_busy_mid"}, {31'd0, bm}, 32'd1);
    if (nbits == 16 && miso_ok) chk({tag, "_miso"}, {16'd0, got}, {16'd0, exp_miso});
    chk({tag, "_wrt_done"}, n_wr - w0, ew);
    chk({tag, "_rd_done"}, n_rd - r0, er);
    chk({tag, "_frame_err"}, n_err - e0, ee);
    chk({tag, "_busy_end"}, {31'd0, spi.busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] got;
    logic        bm;
    int          w0, r0, e0, r;
    logic [5:0]  a;

    for (int i = 0; i < 64; i++) m_ok[i] = 1'b0;
    m_rdq    = 8'h00;
    m_rdq_ok = 1'b1;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
`ifdef EEPROM_WR_PROTECT_EN
    spi.wp = 1'b0;
`endif
    rst = 1'b1;
    wclk(4);
    chk("reset_miso", {31'd0, spi.MISO}, 32'd0);
    chk("reset_busy", {31'd0, spi.busy}, 32'd0);
    chk("reset_wrt_done", {31'd0, spi.wrt_done}, 32'd0);
    chk("reset_rd_done", {31'd0, spi.rd_done}, 32'd0);
    chk("reset_frame_err", {31'd0, spi.frame_err}, 32'd0);
    rst = 1'b0;
    wclk(6);

    // Write, read back, dummy frame carries the byte.
    frame(16'h4A5C, 16, "wr0a");
    frame(16'h0A00, 16, "rd0a");
    frame(16'h0000, 16, "dummy0a");

    // Dump of ch=01, ggg=010: gain then offset.
    frame({2'b01, pack_addr(2'b01, 3'b010, 1'b1), 8'h33}, 16, "wr_gain");
    frame({2'b01, pack_addr(2'b01, 3'b010, 1'b0), 8'h44}, 16, "wr_off");
    frame(16'h1500, 16, "dump_rd_gain");
    frame(16'h1400, 16, "dump_rd_off");
    frame(16'h0000, 16, "dump_dummy");

    // Known contents at 0x00 and 0x01, then a truncated write to 0x01.
    frame(16'h4077, 16, "wr00");
    frame(16'h4121, 16, "wr01");
    frame(16'h41AB, 15, "short_wr01");
    frame(16'h0100, 16, "rd01");
    frame(16'h0000, 16, "dummy01");

    // Reserved opcodes.
    frame(16'h8000, 16, "op10");
    frame(16'hC0FF, 16, "op11");

    // Reset nine bits into a write of 0x0A.
    w0 = n_wr; r0 = n_rd; e0 = n_err;
    xfer(16'h4AFF, 16, 9, got, bm);
    chk("rst_mid_no_pulse", (n_wr - w0) + (n_rd - r0) + (n_err - e0), 0);
    m_rdq    = 8'h00;
    m_rdq_ok = 1'b1;
    frame(16'h0A00, 16, "post_rst_rd0a");
    frame(16'h0000, 16, "post_rst_dummy");

`ifdef EEPROM_WR_PROTECT_EN
    wp_m   = 1'b1;
    spi.wp = 1'b1;
    wclk(4);
    frame(16'h4111, 16, "wp_wr01");
    frame(16'h0100, 16, "wp_rd01");
    frame(16'h0000, 16, "wp_dummy");
    wp_m   = 1'b0;
    spi.wp = 1'b0;
    wclk(4);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      a = 6'($urandom_range(0, 63));
      if (r >= 4 && r <= 6 && !m_ok[a]) r = 0;
      case (r)
        0, 1, 2, 3: frame({2'b01, a, 8'($urandom)}, 16, "rnd_wr");
        4, 5, 6:    frame({2'b00, a, 8'($urandom)}, 16, "rnd_rd");
        7:          frame({1'b1, 1'($urandom), a, 8'($urandom)}, 16, "rnd_resv");
        8:          frame(16'($urandom), $urandom_range(1, 15), "rnd_short");
        default:    frame(16'($urandom), $urandom_range(17, 20), "rnd_long");
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
